// File: rtl/sdram_uart_rx_writer.sv
// sdram_uart_rx_writer: 8N1 UART receiver that pairs bytes (high first) into 16-bit words
// and writes them to sdram_basemod at consecutive addresses through the iCall/oDone handshake.
module sdram_uart_rx_writer #(
  parameter int BAUD_DIV = 1157,
  parameter int HALF_DIV = 578,
  parameter int MAX_ADDR = 511
) (
  input  logic        CLOCK1,
  input  logic        RESET,
  input  logic        RXD,
  output logic [1:0]  oCall,
  input  logic [1:0]  iDone,
  output logic [23:0] oAddr,
  output logic [15:0] oData,
  output logic        oFinish,
  output logic        oFrameErr,
  output logic        oOverrun
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [23:0] ADDR_LAST = 24'(MAX_ADDR);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, hi_q;
  logic [23:0] addr_q;
  logic [15:0] data_q;
  logic pair_q, call_q, inc_q, finish_q, frame_err_q, overrun_q;
  logic rxd, tick, byte_ok, word_ok;
  logic unused_done;
  assign unused_done = iDone[0];
  // Bytes arriving in the cycle the last address is retired are ignored like post-finish bytes.
  always_comb begin
    rxd = sync_q[1];
    tick = cnt_q == (state_q == START ? HALF_LAST : BAUD_LAST);
    byte_ok = state_q == STOP && tick && rxd && !finish_q && !(inc_q && addr_q == ADDR_LAST);
    word_ok = byte_ok && pair_q;
  end
  always_ff @(posedge CLOCK1 or negedge RESET) begin
    if (!RESET) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      hi_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      pair_q <= 1'b0;
      call_q <= 1'b0;
      inc_q <= 1'b0;
      finish_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], RXD};
      frame_err_q <= 1'b0;
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (!rxd) begin
          cnt_q <= '0;
          bit_q <= '0;
          state_q <= START;
        end
        START: if (tick) state_q <= rxd ? IDLE : DATA;
        DATA: if (tick) begin
          shift_q <= {rxd, shift_q[7:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: if (tick) begin
          state_q <= IDLE;
          if (!rxd) begin
            frame_err_q <= 1'b1;
            pair_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (byte_ok) begin
        pair_q <= !pair_q;
        if (!pair_q) hi_q <= shift_q;
      end
      if (word_ok && call_q) overrun_q <= 1'b1;
      if (word_ok && !call_q) begin
        data_q <= {hi_q, shift_q};
        call_q <= 1'b1;
      end else if (call_q && iDone[1]) begin
        call_q <= 1'b0;
        inc_q <= 1'b1;
      end
      if (inc_q) begin
        inc_q <= 1'b0;
        if (addr_q == ADDR_LAST) finish_q <= 1'b1;
        else addr_q <= addr_q + 1'b1;
      end
    end
  end
  assign oCall = {call_q, 1'b0};
  assign oAddr = addr_q;
  assign oData = data_q;
  assign oFinish = finish_q;
  assign oFrameErr = frame_err_q;
  assign oOverrun = overrun_q;
endmodule

// File: tb/tb_sdram_uart_rx_writer.sv
// tb_sdram_uart_rx_writer: table-driven words plus corner sequences, writes scored through an
// expected-write queue; divisors and address range are shrunk to keep the run short.
module tb_sdram_uart_rx_writer;
  localparam int BD = 16;
  localparam int HD = 8;
  localparam int MX = 7;
  localparam int DLY = 5;
  typedef struct {logic [7:0] hi; logic [7:0] lo; logic [15:0] word;} vec_t;
  typedef struct {logic [23:0] addr; logic [15:0] data;} wr_t;
  logic clk = 1'b0, rst_n, rxd;
  logic [1:0] call, done;
  logic [23:0] addr;
  logic [15:0] data;
  logic fin, fe, ovr;
  int checks = 0, errors = 0, fe_cnt = 0, fe_base;
  bit resp_en;
  wr_t q[$];
  vec_t vecs[8];
  sdram_uart_rx_writer #(.BAUD_DIV(BD), .HALF_DIV(HD), .MAX_ADDR(MX)) dut (
    .CLOCK1(clk), .RESET(rst_n), .RXD(rxd), .oCall(call), .iDone(done),
    .oAddr(addr), .oData(data), .oFinish(fin), .oFrameErr(fe), .oOverrun(ovr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rxd = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BD) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (stop_len) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask
  task automatic send_word(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi, 1'b1, BD);
    send_byte(lo, 1'b1, BD);
  endtask
  task automatic chk_all_zero(input string n);
    chk({n, "_call"}, 32'(call), 0);
    chk({n, "_addr"}, 32'(addr), 0);
    chk({n, "_data"}, 32'(data), 0);
    chk({n, "_finish"}, 32'(fin), 0);
    chk({n, "_frame_err"}, 32'(fe), 0);
    chk({n, "_overrun"}, 32'(ovr), 0);
  endtask
  task automatic monitor();
    forever begin
      wr_t w;
      logic [23:0] a;
      @(negedge clk);
      if (resp_en && call[1]) begin
        a = addr;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", addr, data);
        end else begin
          w = q.pop_front();
          chk("wr_addr", 32'(addr), 32'(w.addr));
          chk("wr_data", 32'(data), 32'(w.data));
          a = w.addr;
        end
        repeat (DLY - 1) @(negedge clk);
        chk("wr_hold_addr", 32'(addr), 32'(a));
        done = 2'b10;
        @(negedge clk);
        done = 2'b00;
        chk("wr_call_drop", 32'(call), 0);
        @(negedge clk);
        if (a == 24'(MX)) begin
          chk("wr_finish", 32'(fin), 1);
          chk("wr_addr_hold_max", 32'(addr), MX);
        end else chk("wr_addr_inc", 32'(addr), 32'(a) + 1);
      end
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs = '{'{8'hA0, 8'h00, 16'hA000}, '{8'h12, 8'h34, 16'h1234}, '{8'hFF, 8'hFF, 16'hFFFF},
             '{8'h00, 8'h01, 16'h0001}, '{8'h5A, 8'h5A, 16'h5A5A}, '{8'h80, 8'h01, 16'h8001},
             '{8'h00, 8'hFF, 16'h00FF}, '{8'hC3, 8'h3C, 16'hC33C}};
    rst_n = 1'b0;
    rxd = 1'b1;
    done = 2'b00;
    resp_en = 1'b1;
    fork
      monitor();
      forever @(negedge clk) if (fe) fe_cnt++;
    join_none
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rxd = 1'b0;
    repeat (HD - 3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BD) @(negedge clk);
    chk("glitch_call", 32'(call), 0);
    chk("glitch_frame_err", 32'(fe_cnt), 0);
    for (int i = 0; i < 8; i++) begin
      q.push_back('{24'(i), vecs[i].word});
      send_word(vecs[i].hi, vecs[i].lo);
    end
    repeat (20) @(negedge clk);
    chk("table_pending", 32'(q.size()), 0);
    chk("table_finish", 32'(fin), 1);
    chk("table_addr", 32'(addr), MX);
    send_word(8'h9A, 8'hBC);
    send_word(8'hDE, 8'hF0);
    repeat (20) @(negedge clk);
    chk("post_finish_call", 32'(call), 0);
    chk("post_finish_addr", 32'(addr), MX);
    chk("post_finish_flag", 32'(fin), 1);
    chk("post_finish_frame_err", 32'(fe_cnt), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rearm_finish", 32'(fin), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fe_base = fe_cnt;
    send_byte(8'h12, 1'b1, BD);
    send_byte(8'h34, 1'b0, BD / 2 + 4);
    send_byte(8'h56, 1'b1, BD);
    q.push_back('{24'd0, 16'h5678});
    send_byte(8'h78, 1'b1, BD);
    repeat (20) @(negedge clk);
    chk("frame_err_pulses", 32'(fe_cnt - fe_base), 1);
    chk("frame_err_pending", 32'(q.size()), 0);
    chk("frame_err_addr", 32'(addr), 1);
    resp_en = 1'b0;
    send_word(8'h11, 8'h11);
    chk("ovr_call", 32'(call), 32'h2);
    chk("ovr_first_addr", 32'(addr), 1);
    chk("ovr_first_data", 32'(data), 32'h1111);
    chk("ovr_clear_before", 32'(ovr), 0);
    send_word(8'h22, 8'h22);
    send_word(8'h33, 8'h33);
    chk("ovr_set", 32'(ovr), 1);
    chk("ovr_data_kept", 32'(data), 32'h1111);
    chk("ovr_addr_kept", 32'(addr), 1);
    chk("ovr_call_kept", 32'(call), 32'h2);
    done = 2'b10;
    @(negedge clk);
    done = 2'b00;
    chk("ovr_call_drop", 32'(call), 0);
    @(negedge clk);
    chk("ovr_addr_inc", 32'(addr), 2);
    resp_en = 1'b1;
    q.push_back('{24'd2, 16'h4444});
    send_word(8'h44, 8'h44);
    repeat (20) @(negedge clk);
    chk("ovr_sticky", 32'(ovr), 1);
    chk("ovr_pending", 32'(q.size()), 0);
    send_byte(8'hAB, 1'b1, BD);
    rxd = 1'b0;
    repeat (4 * BD) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    q.push_back('{24'd0, 16'hBEEF});
    send_word(8'hBE, 8'hEF);
    repeat (20) @(negedge clk);
    chk("mid_reset_pending", 32'(q.size()), 0);
    chk("mid_reset_addr", 32'(addr), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
